seg7_display: RTL and testbench

Time-multiplexed driver for a four-digit, common-anode seven-segment display. It takes four BCD digits (ones, tens, hundreds, thousands) from the counter/timekeeping logic. It scans them onto one shared active-low segment bus, with one active-low digit-enable per position. It sits at the top level between the watch datapath and the board's display pins.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/seg7_display.sv | 79 +++++++
 tb/tb_seg7_display.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the four-digit seven-segment scan driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}; enables are active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] DIG_ONES      = 4'b1110;
    localparam logic [3:0] DIG_TENS      = 4'b1101;
    localparam logic [3:0] DIG_HUNDREDS  = 4'b1011;
    localparam logic [3:0] DIG_THOUSANDS = 4'b0111;
    localparam logic [3:0] DIG_OFF       = 4'b1111;

    typedef enum logic [1:0] {
        SEL_ONES      = 2'd0,
        SEL_TENS      = 2'd1,
        SEL_HUNDREDS  = 2'd2,
        SEL_THOUSANDS = 2'd3
    } sel_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-BCD codes blank the digit.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_display.sv
// Time-multiplexed four-digit common-anode display driver.
// Refresh counter top bits pick the digit; outputs are registered.
module seg7_display
    import seg7_pkg::*;
#(
    parameter int CNT_WIDTH = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    output logic [3:0] digit,
    output logic [6:0] number
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [3:0]           digit_q;
    logic [3:0]           digit_d;
    logic [6:0]           number_q;
    logic [6:0]           number_d;
    sel_e                 sel;
    logic [3:0]           bcd_sel;

    assign cnt_d = cnt_q + 1'b1;
    assign sel   = sel_e'(cnt_q[CNT_WIDTH-1 -: 2]);

    // Enable and segment value are derived from the same index so they
    // always land on the same edge.
    always_comb begin
        bcd_sel = ones;
        digit_d = DIG_ONES;
        case (sel)
            SEL_ONES: begin
                bcd_sel = ones;
                digit_d = DIG_ONES;
            end
            SEL_TENS: begin
                bcd_sel = tens;
                digit_d = DIG_TENS;
            end
            SEL_HUNDREDS: begin
                bcd_sel = hundreds;
                digit_d = DIG_HUNDREDS;
            end
            SEL_THOUSANDS: begin
                bcd_sel = thousands;
                digit_d = DIG_THOUSANDS;
            end
            default: begin
                bcd_sel = ones;
                digit_d = DIG_ONES;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd_i (bcd_sel),
        .seg_o (number_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            digit_q  <= DIG_OFF;
            number_q <= SEG_BLANK;
        end else begin
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            number_q <= number_d;
        end
    end

    assign digit  = digit_q;
    assign number = number_q;

endmodule

// File: tb/tb_seg7_display.sv
// Directed bench for seg7_display at CNT_WIDTH=4 (4 clocks per digit).
// Decode table vectors plus scan, mid-frame change, mid-scan reset and wrap.
module tb_seg7_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [3:0] thousands;
    logic [3:0] digit;
    logic [6:0] number;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] val;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs [16];

    always #5 clk = ~clk;

    seg7_display #(.CNT_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .digit     (digit),
        .number    (number)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [10:0] act,
                       input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b_%b want %b_%b", name,
                     act[10:7], act[6:0], exp[10:7], exp[6:0]);
        end
    endtask

    task automatic chk_onehot(input string name);
        int lows;
        lows = 0;
        for (int b = 0; b < 4; b++) if (digit[b] == 1'b0) lows++;
        checks++;
        if (lows != 1) begin
            errors++;
            $display("FAIL %s: digit=%b has %0d low bits, want 1",
                     name, digit, lows);
        end
    endtask

    function automatic logic [10:0] slot_exp(input int s);
        logic [3:0] en;
        logic [3:0] v;
        case (s)
            0:       begin en = 4'b1110; v = ones;      end
            1:       begin en = 4'b1101; v = tens;      end
            2:       begin en = 4'b1011; v = hundreds;  end
            default: begin en = 4'b0111; v = thousands; end
        endcase
        return {en, vecs[v].seg};
    endfunction

    initial begin
        vecs[0]  = '{4'd0,  7'b1000000};
        vecs[1]  = '{4'd1,  7'b1111001};
        vecs[2]  = '{4'd2,  7'b0100100};
        vecs[3]  = '{4'd3,  7'b0110000};
        vecs[4]  = '{4'd4,  7'b0011001};
        vecs[5]  = '{4'd5,  7'b0010010};
        vecs[6]  = '{4'd6,  7'b0000010};
        vecs[7]  = '{4'd7,  7'b1111000};
        vecs[8]  = '{4'd8,  7'b0000000};
        vecs[9]  = '{4'd9,  7'b0010000};
        vecs[10] = '{4'd10, 7'b1111111};
        vecs[11] = '{4'd11, 7'b1111111};
        vecs[12] = '{4'd12, 7'b1111111};
        vecs[13] = '{4'd13, 7'b1111111};
        vecs[14] = '{4'd14, 7'b1111111};
        vecs[15] = '{4'd15, 7'b1111111};

        // Reset held for 3 clocks
        ones = 4'd3; tens = 4'd5; hundreds = 4'd7; thousands = 4'd8;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset", {digit, number}, {4'b1111, 7'b1111111});
        end

        // Scan plus wrap: 3 full frames of 16 clocks
        rst = 1'b0;
        for (int k = 0; k < 48; k++) begin
            step();
            chk($sformatf("scan k=%0d", k), {digit, number},
                slot_exp((k / 4) % 4));
            chk_onehot($sformatf("onehot k=%0d", k));
        end

        // Decode sweep through the ones slot
        for (int i = 0; i < 16; i++) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            ones = vecs[i].val;
            step();
            chk($sformatf("decode %0d", i), {digit, number},
                {4'b1110, vecs[i].seg});
        end

        // Tens changes while ones is displayed
        ones = 4'd3; tens = 4'd5;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("midframe ones", {digit, number}, {4'b1110, 7'b0110000});
        tens = 4'd2;
        repeat (3) step();
        for (int k = 4; k < 8; k++) begin
            step();
            chk($sformatf("midframe tens k=%0d", k), {digit, number},
                {4'b1101, 7'b0100100});
        end

        // Reset while hundreds is displayed
        step();
        chk("hundreds slot", {digit, number}, {4'b1011, 7'b1111000});
        step();
        chk("hundreds slot 2", {digit, number}, {4'b1011, 7'b1111000});
        rst = 1'b1;
        step();
        chk("midscan reset", {digit, number}, {4'b1111, 7'b1111111});
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("restart k=%0d", k), {digit, number},
                slot_exp(k / 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
